// File: rtl/alu_secure_pipe.sv
// alu_secure_pipe: width-parametrised secure ALU with valid/ready on both sides.
// Optional duplicated compute path with sticky fault flag: define ALU_DMR_EN.
module alu_secure_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] WV = WIDTH[WIDTH-1:0];
    localparam int MSB = WIDTH - 1;

    state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;

    logic [WIDTH:0]   p_ext;
    logic [WIDTH-1:0] p_amt;
    logic [WIDTH-1:0] p_res;
    logic             p_c, p_v, p_ill;

    logic             mism;
    logic             fault_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = EXEC;
            end
            EXEC: state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Primary compute path on the latched operands
    always_comb begin
        p_ext = '0;
        p_res = '0;
        p_c   = 1'b0;
        p_v   = 1'b0;
        p_ill = 1'b0;
        p_amt = b_q % WV;
        case (op_q)
            3'b000: begin
                p_ext = {1'b0, a_q} + {1'b0, b_q};
                p_res = p_ext[WIDTH-1:0];
                p_c   = p_ext[WIDTH];
                p_v   = (a_q[MSB] == b_q[MSB]) &&
                        (p_res[MSB] != a_q[MSB]);
            end
            3'b001: begin
                p_ext = {1'b0, a_q} - {1'b0, b_q};
                p_res = p_ext[WIDTH-1:0];
                p_c   = p_ext[WIDTH];
                p_v   = (a_q[MSB] != b_q[MSB]) &&
                        (p_res[MSB] != a_q[MSB]);
            end
            3'b010: p_res = a_q & b_q;
            3'b011: p_res = a_q | b_q;
            3'b100: p_res = a_q ^ b_q;
            3'b101: begin
                // Bit WIDTH catches the last bit shifted out
                p_ext = {1'b0, a_q} << p_amt;
                p_res = p_ext[WIDTH-1:0];
                p_c   = p_ext[WIDTH];
            end
            3'b110: begin
                // Bit 0 catches the last bit shifted out
                p_ext = {a_q, 1'b0} >> p_amt;
                p_res = p_ext[WIDTH:1];
                p_c   = p_ext[0];
            end
            default: p_ill = 1'b1;
        endcase
    end

`ifdef ALU_DMR_EN
    logic [WIDTH-1:0] alt_res;
    logic             alt_c, alt_v;
    logic [WIDTH-1:0] alt_amt;
    logic [WIDTH-1:0] alt_bo;
    logic             alt_ci, alt_cm;

    // Redundant path: ripple adder and bit-serial shifter
    always_comb begin
        alt_res = '0;
        alt_c   = 1'b0;
        alt_v   = 1'b0;
        alt_cm  = 1'b0;
        alt_amt = b_q % WV;
        alt_bo  = (op_q == 3'b001) ? ~b_q : b_q;
        alt_ci  = (op_q == 3'b001);
        case (op_q)
            3'b000, 3'b001: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (i == MSB) alt_cm = alt_ci;
                    alt_res[i] = a_q[i] ^ alt_bo[i] ^ alt_ci;
                    alt_ci = (a_q[i] & alt_bo[i]) |
                             (alt_ci & (a_q[i] ^ alt_bo[i]));
                end
                alt_c = (op_q == 3'b001) ? ~alt_ci : alt_ci;
                alt_v = alt_cm ^ alt_ci;
            end
            3'b010: alt_res = ~(~a_q | ~b_q);
            3'b011: alt_res = ~(~a_q & ~b_q);
            3'b100: alt_res = (a_q | b_q) & ~(a_q & b_q);
            3'b101: begin
                alt_res = a_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i < int'(alt_amt)) begin
                        alt_c   = alt_res[MSB];
                        alt_res = {alt_res[WIDTH-2:0], 1'b0};
                    end
                end
            end
            3'b110: begin
                alt_res = a_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i < int'(alt_amt)) begin
                        alt_c   = alt_res[0];
                        alt_res = {1'b0, alt_res[WIDTH-1:1]};
                    end
                end
            end
            default: alt_res = '0;
        endcase
    end

    assign mism = ({p_res, p_c, p_v} != {alt_res, alt_c, alt_v});
`else
    assign mism = 1'b0;
`endif

    // Operand capture, result registers, fault flag and op counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            fault_q  <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
            if (state == EXEC) begin
                illegal <= p_ill;
                if (mism) begin
                    fault_q  <= 1'b1;
                    result   <= '0;
                    carry    <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b1;
                end else begin
                    result   <= p_res;
                    carry    <= p_c;
                    overflow <= p_v;
                    zero     <= (p_res == '0);
                end
            end
            if (state == DONE && out_ready && op_count != '1) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_alu_secure_pipe.sv
// tb_alu_secure_pipe: scoreboard bench for alu_secure_pipe (WIDTH=8).
// Expected results come from a behavioural model queued at request time.
module tb_alu_secure_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry, zero, overflow, illegal, fault;
    logic [15:0] op_count;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cnt    = 0;

    alu_secure_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero),
        .overflow(overflow), .illegal(illegal),
        .fault(fault), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic [2:0] o);
        exp_t e;
        int amt;
        logic [8:0] s;
        e = '0;
        amt = int'(b) % 8;
        case (o)
            3'd0: begin
                s = a + b;
                e.res = s[7:0];
                e.c = s[8];
                e.v = (a[7] == b[7]) && (e.res[7] != a[7]);
            end
            3'd1: begin
                e.res = a - b;
                e.c = (a < b);
                e.v = (a[7] != b[7]) && (e.res[7] != a[7]);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin
                e.res = a << amt;
                e.c = (amt == 0) ? 1'b0 : a[8-amt];
            end
            3'd6: begin
                e.res = a >> amt;
                e.c = (amt == 0) ? 1'b0 : a[amt-1];
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic run_op(input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [2:0] o,
                          input int hold);
        exp_t e;
        int wt;
        logic [7:0] first;
        @(negedge clk);
        A = a;
        B = b;
        op = o;
        in_valid = 1'b1;
        sb.push_back(model(a, b, o));
        wt = 0;
        while (!in_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~a;
        B = 8'($urandom);
        op = 3'($urandom);
        check("valid_early", out_valid, 0);
        wt = 0;
        while (!out_valid && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("latency", wt, 2);
        first = result;
        for (int h = 0; h < hold; h++) begin
            A = 8'($urandom);
            B = 8'($urandom);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_res", result, first);
            @(negedge clk);
        end
        e = sb.pop_front();
        check("result", result, e.res);
        check("carry", carry, e.c);
        check("zero", zero, e.z);
        check("overflow", overflow, e.v);
        check("illegal", illegal, e.ill);
        check("fault", fault, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        cnt++;
        check("op_count", op_count, cnt);
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        op = '0;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_count", op_count, 0);
        check("rst_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'hFF, 8'h01, 3'd0, 0);
        run_op(8'h80, 8'h01, 3'd1, 0);
        run_op(8'h00, 8'h01, 3'd1, 0);
        run_op(8'h7F, 8'h01, 3'd0, 0);
        run_op(8'h81, 8'h09, 3'd5, 0);
        run_op(8'h01, 8'h08, 3'd6, 0);
        run_op(8'h80, 8'h0F, 3'd6, 0);
        run_op(8'h12, 8'h34, 3'd7, 0);
        run_op(8'hF0, 8'h3C, 3'd2, 0);
        run_op(8'hF0, 8'h0F, 3'd3, 0);
        run_op(8'hAA, 8'hAA, 3'd4, 0);
        run_op(8'h5A, 8'hC3, 3'd0, 5);
        for (int i = 0; i < 12; i++) begin
            run_op(8'($urandom), 8'($urandom),
                   3'($urandom_range(0, 6)), 0);
        end

        // Reset while the op is in EXEC
        @(negedge clk);
        A = 8'h11;
        B = 8'h22;
        op = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        check("abort_result", result, 0);
        check("abort_count", op_count, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet", out_valid, 0);
        end
        run_op(8'h03, 8'h04, 3'd0, 0);

`ifdef ALU_DMR_EN
        @(negedge clk);
        force dut.alt_res = 8'h5A;
        A = 8'h01;
        B = 8'h02;
        op = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        release dut.alt_res;
        check("dmr_valid", out_valid, 1);
        check("dmr_fault", fault, 1);
        check("dmr_result", result, 0);
        check("dmr_zero", zero, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("dmr_sticky", fault, 1);
        rst = 1'b1;
        #1;
        check("dmr_clear", fault, 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
